// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed eight-digit hex driver for a common-anode seven-segment display.
// Scans digits with a blanking guard between them and latches the display word only at frame start.
module sev_seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        frame_start
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    GUARD,
    ACTIVE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      digit_q, digit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     sh_data_q, sh_data_d;
  logic [7:0]      sh_dp_q, sh_dp_d;
  logic            sh_blz_q, sh_blz_d;

  logic [7:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic            fs_d;
  logic [3:0]      nibble;
  logic [7:0]      lz_blank;
  logic            zeros_above;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q + CW'(1);
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_blz_d  = sh_blz_q;

    case (state_q)
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = ACTIVE;
          if (digit_q == 3'd0) begin
            sh_data_d = data_in;
            sh_dp_d   = dp_in;
            sh_blz_d  = blank_lz;
          end
        end
      end
      ACTIVE: begin
        if (cnt_q == DIGIT_LAST) begin
          cnt_d   = '0;
          state_d = GUARD;
          digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = GUARD;
      end
    endcase
  end

  // Digit i is a leading zero when it and every higher in-use nibble are zero.
  always_comb begin
    zeros_above = 1'b1;
    lz_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above & (sh_data_d[4*i +: 4] == 4'h0);
      lz_blank[i] = zeros_above;
    end
  end

  // Outputs are registered from the next-state values so they line up with the state register.
  always_comb begin
    nibble = sh_data_d[{digit_d, 2'b00} +: 4];
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    fs_d   = 1'b0;
    if (state_d == ACTIVE) begin
      an_d[digit_d] = 1'b0;
      seg_d         = (sh_blz_d && lz_blank[digit_d]) ? 7'h7F : decode(nibble);
      dp_d          = ~sh_dp_d[digit_d];
      fs_d          = (state_q == GUARD) && (digit_d == 3'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GUARD;
      digit_q     <= 3'd0;
      cnt_q       <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blz_q    <= 1'b0;
      an_n        <= 8'hFF;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      cnt_q       <= cnt_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blz_q    <= sh_blz_d;
      an_n        <= an_d;
      seg_n       <= seg_d;
      dp_n        <= dp_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Bench for sev_seg_scan_driver: 8-digit and 4-digit instances checked cycle by cycle
// against a frame-position model of the display.
module tb_sev_seg_scan_driver;

  localparam int D = 4;
  localparam int G = 2;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [16:0] BLANK = {8'hFF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg8, seg4;
  logic        dp8, dp4, fs8, fs4;
  logic [7:0]  an8, an4;
  logic [16:0] obs8, obs4, exp8, exp4;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;

  logic [31:0] sd8, sd4;
  logic [7:0]  sdp8, sdp4;
  logic        sb8, sb4;

  always #5 clk = ~clk;

  sev_seg_scan_driver #(.NUM_DIGITS(8), .DIGIT_CYCLES(D), .GUARD_CYCLES(G)) dut8 (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg_n(seg8), .dp_n(dp8), .an_n(an8), .frame_start(fs8)
  );

  sev_seg_scan_driver #(.NUM_DIGITS(4), .DIGIT_CYCLES(D), .GUARD_CYCLES(G)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg_n(seg4), .dp_n(dp4), .an_n(an4), .frame_start(fs4)
  );

  assign obs8 = {an8, seg8, dp8, fs8};
  assign obs4 = {an4, seg4, dp4, fs4};
  assign exp8 = model_out(8, t, sd8, sdp8, sb8);
  assign exp4 = model_out(4, t, sd4, sdp4, sb4);

  // Expected outputs from position in the frame: G blank cycles, then slots of D lit + G blank per digit.
  function automatic logic [16:0] model_out(int n, int tt, logic [31:0] sd, logic [7:0] sdp, logic sb);
    int p, k, w;
    logic [31:0] masked, nib;
    logic [6:0]  sg;
    if (tt < G) return BLANK;
    p = (tt - G) % (n * (D + G));
    k = p / (D + G);
    w = p % (D + G);
    if (w >= D) return BLANK;
    masked = (n == 8) ? sd : (sd & ((32'h1 << (4 * n)) - 32'h1));
    nib    = (sd >> (4 * k)) & 32'hF;
    sg     = (sb && k > 0 && (masked >> (4 * k)) == 32'h0) ? 7'h7F : SEG_TABLE[nib[3:0]];
    return {~(8'h01 << k), sg, ~sdp[k], (p == 0)};
  endfunction

  function automatic logic is_capture(int n, int tt);
    return (tt >= G) && (((tt - G) % (n * (D + G))) == 0);
  endfunction

  function automatic logic model_lit(int n, int tt);
    return (tt >= G) && ((((tt - G) % (n * (D + G))) % (D + G)) < D);
  endfunction

  function automatic int model_digit(int n, int tt);
    return ((tt - G) % (n * (D + G))) / (D + G);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      t = 0;
      sd8 = '0; sdp8 = '0; sb8 = 1'b0;
      sd4 = '0; sdp4 = '0; sb4 = 1'b0;
    end else begin
      t++;
      if (is_capture(8, t)) begin sd8 = data_in; sdp8 = dp_in; sb8 = blank_lz; end
      if (is_capture(4, t)) begin sd4 = data_in; sdp4 = dp_in; sb4 = blank_lz; end
    end
    #0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_in = $urandom(); dp_in = 8'hFF; blank_lz = 1'b1;
    step();
    n_cmp++;
    if (obs8 !== BLANK) begin n_bad++; $display("FAIL reset8: got %h want %h", obs8, BLANK); end
    n_cmp++;
    if (obs4 !== BLANK) begin n_bad++; $display("FAIL reset4: got %h want %h", obs4, BLANK); end
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    data_in = 32'h1234ABCD; dp_in = 8'h00; blank_lz = 1'b0;
    do_reset();
    n_cmp++;
    if (obs8 !== BLANK) begin n_bad++; $display("FAIL first_frame_c0: got %h want %h", obs8, BLANK); end
    for (int i = 0; i < 50; i++) begin
      step();
      n_cmp++;
      if (obs8 !== exp8) begin n_bad++; $display("FAIL first_frame t=%0d: got %h want %h", t, obs8, exp8); end
      case (t)
        1, 6, 7: begin
          n_cmp++;
          if (obs8 !== BLANK) begin n_bad++; $display("FAIL first_blank t=%0d: got %h want %h", t, obs8, BLANK); end
        end
        2: begin
          n_cmp++;
          if (obs8 !== {8'hFE, 7'h21, 1'b1, 1'b1}) begin n_bad++; $display("FAIL first_d0 t=2: got %h want %h", obs8, {8'hFE, 7'h21, 1'b1, 1'b1}); end
        end
        5: begin
          n_cmp++;
          if (obs8 !== {8'hFE, 7'h21, 1'b1, 1'b0}) begin n_bad++; $display("FAIL first_d0 t=5: got %h want %h", obs8, {8'hFE, 7'h21, 1'b1, 1'b0}); end
        end
        8: begin
          n_cmp++;
          if (obs8 !== {8'hFD, 7'h46, 1'b1, 1'b0}) begin n_bad++; $display("FAIL first_d1 t=8: got %h want %h", obs8, {8'hFD, 7'h46, 1'b1, 1'b0}); end
        end
        44: begin
          n_cmp++;
          if (obs8 !== {8'h7F, 7'h79, 1'b1, 1'b0}) begin n_bad++; $display("FAIL first_d7 t=44: got %h want %h", obs8, {8'h7F, 7'h79, 1'b1, 1'b0}); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_decode_sweep();
    logic [31:0] words [2];
    words[0] = 32'h76543210;
    words[1] = 32'hFEDCBA98;
    dp_in = 8'h81; blank_lz = 1'b0;
    for (int w = 0; w < 2; w++) begin
      data_in = words[w];
      for (int i = 0; i < 2 * 8 * (D + G); i++) begin
        step();
        n_cmp++;
        if (obs8 !== exp8) begin n_bad++; $display("FAIL decode t=%0d: got %h want %h", t, obs8, exp8); end
      end
    end
  endtask

  task automatic test_tearing();
    int guard;
    logic seen_new;
    data_in = 32'h11111111; dp_in = 8'h00; blank_lz = 1'b0;
    guard = 0;
    do begin step(); guard++; end while (!is_capture(8, t) && guard < 200);
    do begin step(); guard++; end while (!(model_lit(8, t) && model_digit(8, t) == 3) && guard < 200);
    n_cmp++;
    if (guard >= 200) begin n_bad++; $display("FAIL tearing_sync: got %0d cycles want < 200", guard); end
    data_in  = 32'h22222222;
    seen_new = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (is_capture(8, t)) seen_new = 1'b1;
      n_cmp++;
      if (obs8 !== exp8) begin n_bad++; $display("FAIL tearing t=%0d: got %h want %h", t, obs8, exp8); end
      if (an8 !== 8'hFF) begin
        n_cmp++;
        if (seg8 !== (seen_new ? 7'h24 : 7'h79)) begin
          n_bad++; $display("FAIL tearing_seg t=%0d: got %h want %h", t, seg8, seen_new ? 7'h24 : 7'h79);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [32:0] cases [3];
    cases[0] = {1'b1, 32'h00000050};
    cases[1] = {1'b1, 32'h00000000};
    cases[2] = {1'b0, 32'h00000000};
    dp_in = 8'h00;
    for (int c = 0; c < 3; c++) begin
      {blank_lz, data_in} = cases[c];
      for (int i = 0; i < 2 * 8 * (D + G); i++) begin
        step();
        n_cmp++;
        if (obs8 !== exp8) begin n_bad++; $display("FAIL leading_zero c=%0d t=%0d: got %h want %h", c, t, obs8, exp8); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    data_in = 32'h89ABCDEF; dp_in = 8'h3C; blank_lz = 1'b0;
    do begin step(); guard++; end while (!(model_lit(8, t) && model_digit(8, t) == 5) && guard < 200);
    n_cmp++;
    if (guard >= 200) begin n_bad++; $display("FAIL reset_mid_sync: got %0d cycles want < 200", guard); end
    reset   = 1'b1;
    data_in = $urandom();
    dp_in   = 8'($urandom());
    step();
    n_cmp++;
    if (obs8 !== BLANK) begin n_bad++; $display("FAIL reset_mid: got %h want %h", obs8, BLANK); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (obs8 !== exp8) begin n_bad++; $display("FAIL reset_mid_after t=%0d: got %h want %h", t, obs8, exp8); end
      if (t == 2) begin
        n_cmp++;
        if (seg8 !== SEG_TABLE[data_in[3:0]]) begin
          n_bad++; $display("FAIL reset_mid_d0: got %h want %h", seg8, SEG_TABLE[data_in[3:0]]);
        end
      end
    end
  endtask

  task automatic test_four_digits();
    int last_fs;
    data_in = 32'hFFFF1234; dp_in = 8'h00; blank_lz = 1'b1;
    do_reset();
    last_fs = -1;
    for (int i = 0; i < 90; i++) begin
      step();
      n_cmp++;
      if (obs4 !== exp4) begin n_bad++; $display("FAIL four t=%0d: got %h want %h", t, obs4, exp4); end
      n_cmp++;
      if (an4[7:4] !== 4'hF) begin n_bad++; $display("FAIL four_upper t=%0d: got %h want f", t, an4[7:4]); end
      if (an4 !== 8'hFF) begin
        n_cmp++;
        if (seg4 === 7'h7F) begin n_bad++; $display("FAIL four_noblank t=%0d: got %h want a digit", t, seg4); end
      end
      if (fs4 === 1'b1) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (t - last_fs !== 24) begin n_bad++; $display("FAIL four_period: got %0d want 24", t - last_fs); end
        end
        last_fs = t;
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      data_in = $urandom(); dp_in = 8'($urandom()); blank_lz = 1'($urandom_range(0, 1));
      do_reset();
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          data_in  = $urandom() >> (4 * $urandom_range(0, 8));
          dp_in    = 8'($urandom());
          blank_lz = 1'($urandom_range(0, 1));
        end
        step();
        n_cmp++;
        if (obs8 !== exp8) begin n_bad++; $display("FAIL random8 r=%0d t=%0d: got %h want %h", r, t, obs8, exp8); end
        n_cmp++;
        if (obs4 !== exp4) begin n_bad++; $display("FAIL random4 r=%0d t=%0d: got %h want %h", r, t, obs4, exp4); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; data_in = '0; dp_in = '0; blank_lz = 1'b0;
    test_reset();
    test_first_frame();
    test_decode_sweep();
    test_tearing();
    test_leading_zero();
    test_reset_mid();
    test_four_digits();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
